// File: rtl/i2c_target_model.sv
// I2C target model: oversamples SCL/SDA, ACKs its 7-bit address and serves a
// small register file through an auto-incrementing pointer.
module i2c_target_model #(
  parameter logic [6:0]  TargetAddr = 7'h50,
  parameter int unsigned NumRegs    = 16,
  parameter logic [7:0]  ResetBase  = 8'hA0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_en_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o
);

  localparam int unsigned PtrW = $clog2(NumRegs);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StIgnore
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              ack_drv_q, ack_drv_d;
  logic              rw_q, rw_d;
  logic              first_q, first_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic              sda_en_q, sda_en_d;
  logic              busy_q, busy_d;
  logic              wr_valid_q, wr_valid_d;
  logic [7:0]        wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        regs_q [NumRegs];
  logic [7:0]        regs_d [NumRegs];

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]      rx_byte;
  logic [PtrW-1:0] ptr_inc;

  // Two-flop synchronizers plus one history flop; idle-high bus after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & ~sda_h_q & sda_s2_q;
  assign rx_byte   = {shift_q[6:0], sda_s2_q};
  assign ptr_inc   = ptr_q + 1'b1;

  // Protocol FSM: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ack_drv_d  = ack_drv_q;
    rw_d       = rw_q;
    first_d    = first_q;
    ptr_d      = ptr_q;
    sda_en_d   = sda_en_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;

    if (start_det) begin
      state_d  = StAddr;
      cnt_d    = 4'd0;
      sda_en_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = StIdle;
      cnt_d    = 4'd0;
      sda_en_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d     = 4'd0;
              ack_drv_d = 1'b0;
              if (rx_byte[7:1] == TargetAddr) begin
                state_d = StAddrAck;
                rw_d    = rx_byte[0];
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              ack_drv_d = 1'b1;
              sda_en_d  = 1'b1;
            end else if (rw_q) begin
              // The ACK-release fall also presents the first data MSB.
              state_d  = StRdByte;
              sda_en_d = ~regs_q[ptr_q][7];
              shift_d  = {regs_q[ptr_q][6:0], 1'b0};
              cnt_d    = 4'd1;
            end else begin
              state_d  = StWrByte;
              sda_en_d = 1'b0;
              first_d  = 1'b1;
              cnt_d    = 4'd0;
            end
          end
        end
        StWrByte: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d     = 4'd0;
              ack_drv_d = 1'b0;
              state_d   = StWrAck;
              if (first_q) begin
                ptr_d   = rx_byte[PtrW-1:0];
                first_d = 1'b0;
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_valid_d    = 1'b1;
                wr_addr_d     = 8'(ptr_q);
                wr_data_d     = rx_byte;
                ptr_d         = ptr_inc;
              end
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              ack_drv_d = 1'b1;
              sda_en_d  = 1'b1;
            end else begin
              state_d  = StWrByte;
              sda_en_d = 1'b0;
              cnt_d    = 4'd0;
            end
          end
        end
        StRdByte: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = StRdAck;
              sda_en_d = 1'b0;
              cnt_d    = 4'd0;
            end else begin
              sda_en_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            cnt_d = 4'd0;
            if (!sda_s2_q) begin
              state_d = StRdByte;
              ptr_d   = ptr_inc;
              shift_d = regs_q[ptr_inc];
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StIgnore: sda_en_d = 1'b0;
        default:  state_d = StIdle;
      endcase
    end
  end

  // State, datapath and register file.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      ack_drv_q  <= 1'b0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      ptr_q      <= '0;
      sda_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      for (int unsigned i = 0; i < NumRegs; i++) regs_q[i] <= ResetBase + 8'(i);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ack_drv_q  <= ack_drv_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      ptr_q      <= ptr_d;
      sda_en_q   <= sda_en_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  assign sda_o      = 1'b0;
  assign sda_en_o   = sda_en_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_target_model.sv
// Bench for i2c_target_model: a bit-banged controller plus a register/pointer
// reference model of the target.
module tb_i2c_target_model;

  localparam int NRegs = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_drv, sda_drv;
  logic       sda_line;
  logic       sda_o, sda_en_o, wr_valid_o, busy_o;
  logic [7:0] wr_addr_o, wr_data_o;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] m_regs [NRegs];
  int         m_ptr;

  // Write-strobe log filled by the monitor, consumed via rd_idx.
  logic [7:0] log_addr [256];
  logic [7:0] log_data [256];
  int         wr_n = 0;
  int         rd_idx = 0;
  int         sda_en_cnt = 0;

  logic [7:0] dbuf [4];
  logic [7:0] rbuf [4];

  assign sda_line = sda_drv & ~sda_en_o;

  always #5 clk = ~clk;

  i2c_target_model dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .scl_i      (scl_drv),
    .sda_i      (sda_line),
    .sda_o      (sda_o),
    .sda_en_o   (sda_en_o),
    .wr_valid_o (wr_valid_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .busy_o     (busy_o)
  );

  // Monitor: record write strobes and count cycles with SDA pulled.
  always @(negedge clk) begin
    if (wr_valid_o && wr_n < 256) begin
      log_addr[wr_n] = wr_addr_o;
      log_data[wr_n] = wr_data_o;
      wr_n++;
    end
    if (sda_en_o) sda_en_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] ea, input logic [7:0] ed);
    if (rd_idx < wr_n) begin
      chk({tag, "_addr"}, 32'(log_addr[rd_idx]), 32'(ea));
      chk({tag, "_data"}, 32'(log_data[rd_idx]), 32'(ed));
      rd_idx++;
    end else begin
      chk({tag, "_count"}, 32'(wr_n), 32'(rd_idx + 1));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NRegs; i++) m_regs[i] = 8'hA0 + 8'(i);
    m_ptr = 0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!scl_drv) begin
      wait_clks(5); sda_drv = 1'b1;
      wait_clks(5); scl_drv = 1'b1;
    end
    wait_clks(5); sda_drv = 1'b0;
    wait_clks(5); scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(5); sda_drv = 1'b0;
    wait_clks(5); scl_drv = 1'b1;
    wait_clks(5); sda_drv = 1'b1;
    wait_clks(10);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wait_clks(5); sda_drv = b[i];
      wait_clks(5); scl_drv = 1'b1;
      wait_clks(10); scl_drv = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    wait_clks(5); sda_drv = 1'b1;
    wait_clks(5); scl_drv = 1'b1;
    wait_clks(5); ack = ~sda_line;
    wait_clks(5); scl_drv = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      wait_clks(5); sda_drv = 1'b1;
      wait_clks(5); scl_drv = 1'b1;
      wait_clks(5); b[i] = sda_line;
      wait_clks(5); scl_drv = 1'b0;
    end
    wait_clks(5); sda_drv = nack;
    wait_clks(5); scl_drv = 1'b1;
    wait_clks(10); scl_drv = 1'b0;
  endtask

  // Write transaction: pointer byte then n data bytes from dbuf.
  task automatic tx_write(input logic [7:0] ptr_byte, input int n);
    logic a;
    i2c_start();
    send_byte(8'hA0, a);
    chk("wr_addr_ack", 32'(a), 32'd1);
    chk("busy_in_xfer", 32'(busy_o), 32'd1);
    send_byte(ptr_byte, a);
    chk("wr_ptr_ack", 32'(a), 32'd1);
    m_ptr = int'(ptr_byte) % NRegs;
    for (int k = 0; k < n; k++) begin
      send_byte(dbuf[k], a);
      chk("wr_data_ack", 32'(a), 32'd1);
      chk_wr("wr_strobe", 8'(m_ptr), dbuf[k]);
      m_regs[m_ptr] = dbuf[k];
      m_ptr = (m_ptr + 1) % NRegs;
    end
    i2c_stop();
    chk("busy_after_stop", 32'(busy_o), 32'd0);
    chk("no_extra_strobe", 32'(wr_n), 32'(rd_idx));
  endtask

  // Read transaction, optionally setting the pointer first via repeated START.
  task automatic tx_read(input logic set_ptr, input logic [7:0] ptr_byte, input int n);
    logic a;
    logic [7:0] b;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'hA0, a);
      chk("rd_waddr_ack", 32'(a), 32'd1);
      send_byte(ptr_byte, a);
      chk("rd_ptr_ack", 32'(a), 32'd1);
      m_ptr = int'(ptr_byte) % NRegs;
      i2c_start();
    end
    send_byte(8'hA1, a);
    chk("rd_addr_ack", 32'(a), 32'd1);
    for (int k = 0; k < n; k++) begin
      recv_byte(b, (k == n - 1));
      rbuf[k] = b;
      chk("rd_data", 32'(b), 32'(m_regs[m_ptr]));
      if (k != n - 1) m_ptr = (m_ptr + 1) % NRegs;
    end
    chk("rd_release_after_nack", 32'(sda_en_o), 32'd0);
    i2c_stop();
    chk("busy_after_stop", 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic a;
    int snap;
    int kind;
    int n;

    rst_n = 1'b0;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    model_reset();
    wait_clks(3);
    chk("rst_sda_en", 32'(sda_en_o), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid_o), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
    chk("rst_wr_data", 32'(wr_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    wait_clks(10);
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Basic write: pointer 3, then 0x5A, 0xC3.
    dbuf[0] = 8'h5A;
    dbuf[1] = 8'hC3;
    tx_write(8'h03, 2);
    chk("tp1_reg3", 32'(log_addr[0]), 32'h03);
    chk("tp1_reg4_data", 32'(log_data[1]), 32'hC3);

    // Read back with repeated START: 0x5A, 0xC3, 0xA5.
    tx_read(1'b1, 8'h03, 3);
    chk("tp2_b0", 32'(rbuf[0]), 32'h5A);
    chk("tp2_b2", 32'(rbuf[2]), 32'hA5);

    // Pointer wrap on read and on write.
    tx_read(1'b1, 8'h0F, 2);
    chk("wrap_rd_b0", 32'(rbuf[0]), 32'hAF);
    chk("wrap_rd_b1", 32'(rbuf[1]), 32'hA0);
    dbuf[0] = 8'h11;
    dbuf[1] = 8'h22;
    tx_write(8'h0F, 2);

    // Address mismatch: no ACK, no strobes, no SDA drive.
    snap = sda_en_cnt;
    i2c_start();
    send_byte(8'hA2, a);
    chk("mismatch_addr_nack", 32'(a), 32'd0);
    send_byte(8'h05, a);
    chk("mismatch_data_nack", 32'(a), 32'd0);
    send_byte(8'h77, a);
    i2c_stop();
    chk("mismatch_no_drive", 32'(sda_en_cnt), 32'(snap));
    chk("mismatch_no_strobe", 32'(wr_n), 32'(rd_idx));
    tx_read(1'b1, 8'h05, 2);

    // Pointer byte beyond depth is taken modulo the depth.
    dbuf[0] = 8'($urandom_range(0, 255));
    tx_write(8'h23, 1);
    tx_read(1'b1, 8'h03, 1);

    // Reset while the address ACK is being driven.
    i2c_start();
    send_bits(8'hA0);
    wait_clks(5); sda_drv = 1'b1;
    wait_clks(5);
    chk("ack_driven_before_rst", 32'(sda_en_o), 32'd1);
    rst_n = 1'b0;
    wait_clks(2);
    chk("rst_mid_sda_en", 32'(sda_en_o), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    wait_clks(3);
    rst_n = 1'b1;
    model_reset();
    scl_drv = 1'b1;
    wait_clks(10); scl_drv = 1'b0;
    snap = sda_en_cnt;
    send_byte(8'hA0, a);
    chk("post_rst_no_ack0", 32'(a), 32'd0);
    send_byte(8'h02, a);
    chk("post_rst_no_ack1", 32'(a), 32'd0);
    i2c_stop();
    chk("post_rst_no_drive", 32'(sda_en_cnt), 32'(snap));
    chk("post_rst_no_strobe", 32'(wr_n), 32'(rd_idx));
    tx_read(1'b0, 8'h00, 2);
    dbuf[0] = 8'($urandom_range(0, 255));
    tx_write(8'h02, 1);
    tx_read(1'b1, 8'h00, 4);

    // Randomized transactions against the model.
    for (int t = 0; t < 10; t++) begin
      kind = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 4));
      if (kind == 0) begin
        for (int k = 0; k < 4; k++) dbuf[k] = 8'($urandom_range(0, 255));
        tx_write(8'($urandom_range(0, 255)), n);
      end else begin
        tx_read(kind == 1, 8'($urandom_range(0, 255)), n);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
